// File: rtl/sha_round_ctrl.sv
// Sequencing controller for a SHA-256 compression core: accepts message blocks,
// steps the 64 rounds, chains hashes across blocks and hands off the digest.
module sha_round_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       blk_first,
  input  logic       blk_last,
  output logic       round_init,
  input  logic [5:0] round_in,
  input  logic       round_last,
  output logic       core_load,
  output logic       core_iv_sel,
  output logic       core_rnd_en,
  output logic       core_add,
  output logic       dig_valid,
  input  logic       dig_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [5:0] LAST_FLAG_RND = 6'd62;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       first_q;
  logic       last_q;
  logic       fin_q;
  logic       chain_q;
  logic [5:0] sh;
  logic       accept;
  logic       rnd_err;

  assign accept = (state == IDLE) && blk_valid;

  // Shadow counter cross-checks the external round counter every RUN cycle.
  assign rnd_err = (state == RUN) &&
                   ((round_in != sh) || (round_last && (sh != LAST_FLAG_RND)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (blk_valid) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (fin_q) state_nxt = ADD;
      ADD:     state_nxt = last_q ? DONE : IDLE;
      DONE:    if (dig_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    blk_ready   = (state == IDLE);
    round_init  = (state != RUN);
    core_load   = (state == LOAD);
    core_iv_sel = (state == LOAD) && first_q;
    core_rnd_en = (state == RUN);
    core_add    = (state == ADD);
    dig_valid   = (state == DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
      chain_q <= 1'b0;
      sh      <= 6'd0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        first_q <= blk_first;
        last_q  <= blk_last;
        // A fresh message discards any half-finished chain without complaint.
        if (blk_first) chain_q <= 1'b0;
        if (!blk_first && !chain_q) err <= 1'b1;
      end
      if (state == LOAD) sh <= 6'd0;
      if (state == RUN) begin
        sh <= sh + 6'd1;
        // fin_q marks round 63: set on the round_last cycle, cleared on leaving RUN.
        if (fin_q)           fin_q <= 1'b0;
        else if (round_last) fin_q <= 1'b1;
      end
      if (rnd_err) err <= 1'b1;
      if ((state == ADD) && !last_q) chain_q <= 1'b1;
      if ((state == DONE) && dig_ready) chain_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: models the round counter and checks block
// sequencing, chaining, backpressure, error flagging and reset behaviour.
module tb_sha_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       blk_valid;
  logic       blk_ready;
  logic       blk_first;
  logic       blk_last;
  logic       round_init;
  logic [5:0] round_in;
  logic       round_last;
  logic       core_load;
  logic       core_iv_sel;
  logic       core_rnd_en;
  logic       core_add;
  logic       dig_valid;
  logic       dig_ready;
  logic       busy;
  logic       err;

  int         total;
  int         passed;
  logic [5:0] cnt;
  bit         skip_mode;
  bit         err_exp;
  bit         chain_exp;

  sha_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .round_init (round_init),
    .round_in   (round_in),
    .round_last (round_last),
    .core_load  (core_load),
    .core_iv_sel(core_iv_sel),
    .core_rnd_en(core_rnd_en),
    .core_add   (core_add),
    .dig_valid  (dig_valid),
    .dig_ready  (dig_ready),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input string name, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s/%s: observed %0d expected %0d", tag, name, obs, exp);
  endtask

  function automatic int out_vec();
    return int'({blk_ready, round_init, core_load, core_iv_sel, core_rnd_en,
                 core_add, dig_valid, busy, err});
  endfunction

  localparam int RESET_VEC = 9'b110000000;

  // One clock: external round counter follows round_init / core_rnd_en.
  task automatic tick();
    logic init_s;
    logic en_s;
    init_s = round_init;
    en_s   = core_rnd_en;
    @(posedge clk);
    #1;
    if (init_s)    cnt = 6'd0;
    else if (en_s) cnt = (skip_mode && cnt == 6'd16) ? 6'd18 : cnt + 6'd1;
    round_in   = cnt;
    round_last = (cnt == 6'd62);
  endtask

  task automatic run_block(input bit first, input bit last, input int hold,
                           input bit skip, input string tag);
    int n_load, load_at, n_rnd, rnd_mis, n_add, add_at, dig_at;
    int done_cnt, done_bad, onehot_bad, iv;
    n_load = 0; load_at = 0; n_rnd = 0; rnd_mis = 0; n_add = 0; add_at = 0;
    dig_at = 0; done_cnt = 0; done_bad = 0; onehot_bad = 0; iv = -1;
    skip_mode = skip;
    if (!first && !chain_exp) err_exp = 1'b1;
    if (skip) err_exp = 1'b1;
    blk_valid = 1'b1; blk_first = first; blk_last = last; dig_ready = 1'b0;
    tick();
    for (int n = 1; n <= 200; n++) begin
      if (int'(core_load) + int'(core_rnd_en) + int'(core_add) > 1) onehot_bad++;
      if (core_load) begin n_load++; load_at = n; iv = int'(core_iv_sel); end
      if (core_rnd_en) begin
        if (int'(round_in) != n_rnd) rnd_mis++;
        n_rnd++;
      end
      if (core_add) begin n_add++; add_at = n; end
      if (dig_valid) begin
        if (dig_at == 0) dig_at = n;
        done_cnt++;
      end
      if (dig_at != 0 && busy && (!dig_valid || blk_ready)) done_bad++;
      if (!busy) break;
      blk_valid = ($urandom_range(0, 1) != 0);
      blk_first = ($urandom_range(0, 1) != 0);
      blk_last  = ($urandom_range(0, 1) != 0);
      if (dig_at != 0) dig_ready = ((n - dig_at) >= hold);
      else             dig_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    blk_valid = 1'b0;
    dig_ready = 1'b0;
    chain_exp = !last;
    skip_mode = 1'b0;
    chk(tag, "idle", int'(busy), 0);
    chk(tag, "ready_after", int'(blk_ready), 1);
    chk(tag, "add_cnt", n_add, 1);
    chk(tag, "err", int'(err), int'(err_exp));
    if (!skip) begin
      chk(tag, "load_cnt", n_load, 1);
      chk(tag, "load_at", load_at, 1);
      chk(tag, "iv_sel", iv, int'(first));
      chk(tag, "rnd_cnt", n_rnd, 64);
      chk(tag, "rnd_order", rnd_mis, 0);
      chk(tag, "add_at", add_at, 66);
      chk(tag, "dig_at", dig_at, last ? 67 : 0);
      chk(tag, "done_cycles", done_cnt, last ? hold + 1 : 0);
      chk(tag, "done_hold", done_bad, 0);
      chk(tag, "onehot", onehot_bad, 0);
    end
  endtask

  task automatic reset_at(input int stop_n, input string tag);
    int n_add, n_busy;
    n_add = 0; n_busy = 0;
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1; dig_ready = 1'b0;
    tick();
    blk_valid = 1'b0;
    for (int n = 1; n < stop_n; n++) tick();
    if (stop_n == 32) chk(tag, "round_before", int'(round_in), 30);
    else              chk(tag, "dig_before", int'(dig_valid), 1);
    rst_n = 1'b0;
    #1;
    chk(tag, "rst_outputs", out_vec(), RESET_VEC);
    tick();
    tick();
    rst_n = 1'b1;
    err_exp = 1'b0;
    chain_exp = 1'b0;
    chk(tag, "post_rst_outputs", out_vec(), RESET_VEC);
    for (int n = 0; n < 80; n++) begin
      if (core_add) n_add++;
      if (busy) n_busy++;
      tick();
    end
    chk(tag, "no_add", n_add, 0);
    chk(tag, "stays_idle", n_busy, 0);
  endtask

  initial begin
    total = 0; passed = 0; cnt = 6'd0; skip_mode = 1'b0;
    err_exp = 1'b0; chain_exp = 1'b0;
    rst_n = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    dig_ready = 1'b0; round_in = 6'd0; round_last = 1'b0;
    #12;
    chk("reset", "during", out_vec(), RESET_VEC);
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset", "after", out_vec(), RESET_VEC);

    // Single-block message with immediate digest acceptance.
    run_block(1'b1, 1'b1, 0, 1'b0, "single");
    // Two-block message, digest backpressured for 10 cycles.
    run_block(1'b1, 1'b0, 0, 1'b0, "two_a");
    run_block(1'b0, 1'b1, 10, 1'b0, "two_b");
    // New message abandons a pending chain without raising err.
    run_block(1'b1, 1'b0, 0, 1'b0, "discard_a");
    run_block(1'b1, 1'b1, 3, 1'b0, "discard_b");
    // Continuation block with no chain in progress.
    run_block(1'b0, 1'b1, 2, 1'b0, "no_first");

    // Reset mid-RUN clears err and drops the block.
    reset_at(32, "rst_run");
    run_block(1'b1, 1'b1, 0, 1'b0, "after_rst");

    // Round counter skipping round 17.
    run_block(1'b1, 1'b1, 1, 1'b1, "skip17");

    // Reset while a digest is pending.
    reset_at(70, "rst_done");

    for (int i = 0; i < 8; i++) begin
      bit f, l;
      int h;
      f = ($urandom_range(0, 1) != 0);
      l = ($urandom_range(0, 1) != 0);
      h = int'($urandom_range(0, 12));
      run_block(f, l, h, 1'b0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 blk_valid  input  1  upstream has a 512-bit message block ready.
REQ-004 blk_ready  output  1  controller can accept a block.
REQ-005 blk_first  input  1  block starts a new message (use IV); sampled at accept.
REQ-006 blk_last  input  1  block ends the message; sampled at accept.
REQ-007 round_init  output  1  drives the round counter's init input.
REQ-008 round_in  input  6  current round index from the round counter.
REQ-009 round_last  input  1  round counter flag, high when round_in==62.
REQ-010 core_load  output  1  datapath loads working variables a..h.
REQ-011 core_iv_sel  output  1  1 = load from IV, 0 = load from chained hash.
REQ-012 core_rnd_en  output  1  datapath executes one compression round this cycle.
REQ-013 core_add  output  1  datapath adds working variables into the hash state.
REQ-014 dig_valid  output  1  final digest available.
REQ-015 dig_ready  input  1  downstream accepts the digest.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 The FSM SHALL have five states: IDLE, LOAD, RUN, ADD and DONE.
REQ-019 IDLE SHALL behave as follows:
- blk_ready=1 and round_init=1.
- A block is accepted when blk_valid&blk_ready; first_q<=blk_first, last_q<=blk_last, next state LOAD.
REQ-020 LOAD SHALL last one cycle with core_load=1, core_iv_sel=first_q and round_init=1, then go to RUN.
REQ-021 RUN SHALL behave as follows:
- core_rnd_en=1, round_init=0.
- fin_q is set in the RUN cycle where round_last=1.
- The RUN cycle with fin_q=1 is round 63; the next state is ADD and fin_q clears.
REQ-022 ADD SHALL last one cycle with core_add=1.
- Next state DONE if last_q=1.
- Otherwise next state IDLE and chain_q is set.
REQ-023 DONE SHALL hold dig_valid=1 until dig_ready=1, then go to IDLE; chain_q clears.
REQ-024 RUN SHALL last exactly 64 cycles; round_in SHALL take values 0..63 in order.
REQ-025 Latency: dig_valid SHALL rise exactly 66 rising edges after the accepting edge (1 LOAD + 64 RUN + 1 ADD).
REQ-026 A 6-bit shadow counter sh SHALL behave as follows:
- Clears in LOAD and increments each RUN cycle.
- err is set if round_in!=sh in any RUN cycle.
- err is set if round_last=1 in RUN while sh!=62.
REQ-027 Accepting a block with blk_first=0 while chain_q=0 SHALL set err; the block is still processed with core_iv_sel=0.
REQ-028 Accepting a block with blk_first=1 while chain_q=1 SHALL discard the chain (chain_q clears) and SHALL NOT set err.
REQ-029 err SHALL be sticky, cleared only by reset, and SHALL NOT alter FSM sequencing.
REQ-030 blk_valid SHALL be ignored outside IDLE; dig_ready SHALL be ignored outside DONE.
REQ-031 When dig_valid and dig_ready are both high, the FSM SHALL enter IDLE, and a new block SHALL be acceptable on the following cycle.
REQ-032 At most one of core_load, core_rnd_en and core_add SHALL be high in any cycle.

Reset
REQ-033 On rst_n low, the block SHALL asynchronously enter IDLE and clear first_q, last_q, fin_q, chain_q, sh and err.
REQ-034 Output values during and after reset SHALL be:
- blk_ready=1, round_init=1.
- core_load=0, core_iv_sel=0, core_rnd_en=0, core_add=0.
- dig_valid=0, busy=0, err=0.
REQ-035 Reset asserted mid-RUN or in DONE SHALL abandon the block with no core_add pulse; a pending digest SHALL be dropped.

Verification
REQ-036 Single block: first=1, last=1, dig_ready=1 -> LOAD with iv_sel=1, then 64 rnd_en cycles with round_in 0..63, then one core_add; dig_valid at edge 66; err=0.
REQ-037 Two-block message: block A with first=1, last=0, then block B with first=0, last=1 -> two core_add pulses, B loads with iv_sel=0, only one dig_valid, err=0.
REQ-038 Backpressure: dig_ready held 0 for 10 cycles -> dig_valid stays 1, blk_ready=0 and busy=1 throughout; IDLE on the first cycle after dig_ready=1.
REQ-039 Protocol error cases:
- Block with first=0 after reset -> err=1 and the block completes normally.
- Counter model forced to skip round 17 -> err=1.
REQ-040 Reset pulse at round 30 -> all outputs at reset values immediately; no core_add; the next block runs a full 64 rounds with err=0.
